rx_tlp_trigger: RTL and testbench

RX_TLP_TRIGGER -- requirements
Module: rx_tlp_trigger

---
 rtl/rx_tlp_trigger_pkg.sv | 26 ++
 rtl/rx_tlp_trigger_counter.sv | 18 +
 rtl/rx_tlp_trigger.sv | 142 ++++++++++++++
 tb/tb_rx_tlp_trigger.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_tlp_trigger_pkg.sv
// Shared constants for the RX TLP trigger and the TLP sender: defaults, widths,
// FSM state encoding and the chunk sizing helper.
package rx_tlp_trigger_pkg;

  localparam int BF_DEF     = 9;
  localparam int MAX_QW_DEF = 16;
  localparam int HP_QW_DEF  = 262128;   // 2 MiB page minus the 0x80-byte header, in qwords
  localparam int QW_W       = 5;
  localparam int PAGE_W     = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_COMMIT,
    ST_LAST,
    ST_CLOSE
  } trig_state_t;

  function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/rx_tlp_trigger_counter.sv
// Saturating idle-cycle counter; held at zero while clr is asserted.
module rx_qw_saturating_counter #(
  parameter int W = 8
) (
  input  logic         trn_clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n)                cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && cnt != '1)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/rx_tlp_trigger.sv
// Decides when the RX buffer holds enough data to send a TLP into the current
// host huge page, and when that page must be closed and returned.
module rx_tlp_trigger
  import rx_tlp_trigger_pkg::*;
#(
  parameter int BF           = BF_DEF,
  parameter int MAX_QW       = MAX_QW_DEF,
  parameter int HP_QW        = HP_QW_DEF,
  parameter int TLP_TIMEOUT  = 64,
  parameter int PAGE_TIMEOUT = 4096
) (
  input  logic            trn_clk,
  input  logic            reset_n,
  input  logic [BF:0]     wr_addr,
  input  logic [BF:0]     commited_rd_address,
  input  logic            huge_page_available,
  output logic            trigger_tlp,
  input  logic            trigger_tlp_ack,
  output logic            send_last_tlp,
  output logic            change_huge_page,
  input  logic            change_huge_page_ack,
  output logic [QW_W-1:0] qwords_to_send
);

  localparam int AW = BF + 1;
  localparam int IW = $clog2(TLP_TIMEOUT + 1);
  localparam int PW = $clog2(PAGE_TIMEOUT + 1);
  localparam logic [31:0] MAXQ_L  = 32'(MAX_QW);
  localparam logic [31:0] HP_L    = 32'(HP_QW);
  localparam logic [31:0] TTO_L   = 32'(TLP_TIMEOUT);
  localparam logic [31:0] PTO_L   = 32'(PAGE_TIMEOUT);

  trig_state_t       state;
  logic [AW-1:0]     avail;
  logic [AW-1:0]     target;
  logic [PAGE_W-1:0] page_used;
  logic [IW-1:0]     idle_cnt;
  logic [PW-1:0]     page_idle_cnt;
  logic              last_ack_seen;

  logic [31:0] avail_w, rem_w, chunk_w;
  logic        last_ok, tlp_ok, page_to, commit_hit;

  // Modular difference handles pointer wrap; equal pointers mean empty.
  assign avail      = wr_addr - commited_rd_address;
  assign avail_w    = 32'(avail);
  assign rem_w      = HP_L - 32'(page_used);
  assign chunk_w    = min3(avail_w, MAXQ_L, rem_w);
  assign last_ok    = (rem_w != '0) && (rem_w <= MAXQ_L) && (avail_w >= rem_w);
  assign tlp_ok     = (avail_w >= MAXQ_L) || ((avail_w != '0) && (32'(idle_cnt) >= TTO_L));
  assign page_to    = (page_used != '0) && (avail_w == '0) && (32'(page_idle_cnt) >= PTO_L);
  assign commit_hit = (commited_rd_address == target);

  rx_qw_saturating_counter #(.W(IW)) u_idle_cnt (
    .trn_clk (trn_clk),
    .reset_n (reset_n),
    .clr     (state != ST_IDLE),
    .inc     ((state == ST_IDLE) && (avail_w != '0) && (avail_w < MAXQ_L)),
    .cnt     (idle_cnt)
  );

  rx_qw_saturating_counter #(.W(PW)) u_page_idle_cnt (
    .trn_clk (trn_clk),
    .reset_n (reset_n),
    .clr     (state != ST_IDLE),
    .inc     ((state == ST_IDLE) && (avail_w == '0) && (page_used != '0)),
    .cnt     (page_idle_cnt)
  );

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      trigger_tlp      <= 1'b0;
      send_last_tlp    <= 1'b0;
      change_huge_page <= 1'b0;
      qwords_to_send   <= '0;
      page_used        <= '0;
      target           <= '0;
      last_ack_seen    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          last_ack_seen <= 1'b0;
          if (huge_page_available && rem_w == '0) begin
            change_huge_page <= 1'b1;
            state            <= ST_CLOSE;
          end else if (huge_page_available && last_ok) begin
            qwords_to_send <= QW_W'(chunk_w);
            target         <= commited_rd_address + AW'(chunk_w);
            send_last_tlp  <= 1'b1;
            state          <= ST_LAST;
          end else if (huge_page_available && tlp_ok) begin
            qwords_to_send <= QW_W'(chunk_w);
            target         <= commited_rd_address + AW'(chunk_w);
            trigger_tlp    <= 1'b1;
            state          <= ST_REQ;
          end else if (page_to) begin
            change_huge_page <= 1'b1;
            state            <= ST_CLOSE;
          end
        end
        ST_REQ: begin
          if (trigger_tlp_ack) begin
            trigger_tlp <= 1'b0;
            state       <= ST_WAIT_COMMIT;
          end
        end
        ST_WAIT_COMMIT: begin
          if (commit_hit) begin
            page_used <= page_used + PAGE_W'(qwords_to_send);
            state     <= ST_IDLE;
          end
        end
        ST_LAST: begin
          // The sender may chain the page close itself; its ack can land before,
          // with, or never before the final commit.
          if (commit_hit && (change_huge_page_ack || last_ack_seen)) begin
            send_last_tlp <= 1'b0;
            page_used     <= '0;
            state         <= ST_IDLE;
          end else if (commit_hit) begin
            send_last_tlp    <= 1'b0;
            page_used        <= PAGE_W'(HP_QW);
            change_huge_page <= 1'b1;
            state            <= ST_CLOSE;
          end else if (change_huge_page_ack) begin
            last_ack_seen <= 1'b1;
          end
        end
        ST_CLOSE: begin
          if (change_huge_page_ack) begin
            change_huge_page <= 1'b0;
            page_used        <= '0;
            state            <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_tlp_trigger.sv
// Directed scenarios followed by randomized buffer fills, checked against a
// transaction-level model of page accounting and request selection.
module tb_rx_tlp_trigger;

  localparam int BF   = 9;
  localparam int AMOD = 1024;
  localparam int MAXQ = 16;
  localparam int HP   = 200;
  localparam int TTO  = 64;
  localparam int PTO  = 4096;
  localparam int K_NONE = 0, K_TRIG = 1, K_LAST = 2, K_CLOSE = 3;

  logic        trn_clk, reset_n;
  logic [BF:0] wr_addr, commited_rd_address;
  logic        huge_page_available, trigger_tlp, trigger_tlp_ack;
  logic        send_last_tlp, change_huge_page, change_huge_page_ack;
  logic [4:0]  qwords_to_send;

  int wr_i, cm_i, pu;
  int tests, fails;

  assign wr_addr             = 10'(wr_i);
  assign commited_rd_address = 10'(cm_i);

  rx_tlp_trigger #(
    .BF(BF), .MAX_QW(MAXQ), .HP_QW(HP), .TLP_TIMEOUT(TTO), .PAGE_TIMEOUT(PTO)
  ) dut (
    .trn_clk              (trn_clk),
    .reset_n              (reset_n),
    .wr_addr              (wr_addr),
    .commited_rd_address  (commited_rd_address),
    .huge_page_available  (huge_page_available),
    .trigger_tlp          (trigger_tlp),
    .trigger_tlp_ack      (trigger_tlp_ack),
    .send_last_tlp        (send_last_tlp),
    .change_huge_page     (change_huge_page),
    .change_huge_page_ack (change_huge_page_ack),
    .qwords_to_send       (qwords_to_send)
  );

  initial trn_clk = 1'b0;
  always #5 trn_clk = ~trn_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge trn_clk);
    #1;
    chk("at_most_one_req",
        32'($countones({trigger_tlp, send_last_tlp, change_huge_page}) <= 1), 1);
  endtask

  function automatic int avail_now();
    return (wr_i - cm_i + AMOD) % AMOD;
  endfunction

  function automatic int cur_kind();
    if (trigger_tlp)      return K_TRIG;
    if (send_last_tlp)    return K_LAST;
    if (change_huge_page) return K_CLOSE;
    return K_NONE;
  endfunction

  task automatic add_data(input int n);
    wr_i = (wr_i + n) % AMOD;
  endtask

  task automatic commit(input int n);
    cm_i = (cm_i + n) % AMOD;
  endtask

  task automatic pulse_change_ack();
    change_huge_page_ack = 1'b1;
    tick();
    change_huge_page_ack = 1'b0;
  endtask

  // Predict the next request from page fill and buffer level, wait for it,
  // then act as the sender: ack, commit, and close the page when asked.
  task automatic serve(input string tag);
    int av, rem, ek, eq, k, chained;
    av  = avail_now();
    rem = HP - pu;
    eq  = 0;
    if (rem == 0)                        ek = K_CLOSE;
    else if (rem <= MAXQ && av >= rem) begin ek = K_LAST; eq = rem; end
    else if (av > 0) begin
      ek = K_TRIG;
      eq = (av < MAXQ) ? av : MAXQ;
      if (rem < eq) eq = rem;
    end else                             ek = K_CLOSE;
    k = cur_kind();
    for (int i = 0; i < PTO + 200 && k == K_NONE; i++) begin
      tick();
      k = cur_kind();
    end
    chk({tag, "_kind"}, k, ek);
    if (k != ek) begin
      $display("FAIL %s: request kind diverged from model, stopping", tag);
      $fatal(1, "diverged");
    end
    if (k != K_CLOSE) chk({tag, "_qw"}, qwords_to_send, eq);
    repeat ($urandom_range(0, 2)) tick();
    case (k)
      K_TRIG: begin
        chk({tag, "_trig_hold"}, trigger_tlp, 1);
        chk({tag, "_qw_stable"}, qwords_to_send, eq);
        trigger_tlp_ack = 1'b1;
        tick();
        trigger_tlp_ack = 1'b0;
        chk({tag, "_trig_clr"}, trigger_tlp, 0);
        repeat ($urandom_range(0, 2)) tick();
        commit(eq);
        tick();
        pu += eq;
        chk({tag, "_trig_done"}, trigger_tlp, 0);
      end
      K_LAST: begin
        chk({tag, "_last_hold"}, send_last_tlp, 1);
        commit(eq);
        chained = int'($urandom_range(0, 1));
        if (chained != 0) begin
          pulse_change_ack();
          chk({tag, "_chain_last_clr"}, send_last_tlp, 0);
          chk({tag, "_chain_no_close"}, change_huge_page, 0);
        end else begin
          tick();
          chk({tag, "_last_clr"}, send_last_tlp, 0);
          chk({tag, "_close_req"}, change_huge_page, 1);
          repeat ($urandom_range(0, 2)) tick();
          pulse_change_ack();
          chk({tag, "_close_clr"}, change_huge_page, 0);
        end
        pu = 0;
      end
      default: begin
        pulse_change_ack();
        chk({tag, "_close_clr"}, change_huge_page, 0);
        pu = 0;
      end
    endcase
  endtask

  initial begin
    int early;
    tests = 0; fails = 0;
    wr_i = 0; cm_i = 0; pu = 0;
    huge_page_available  = 1'b0;
    trigger_tlp_ack      = 1'b0;
    change_huge_page_ack = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    tick(); tick();
    chk("rst_trigger", trigger_tlp, 0);
    chk("rst_last", send_last_tlp, 0);
    chk("rst_change", change_huge_page, 0);
    chk("rst_qw", qwords_to_send, 0);
    reset_n = 1'b1;
    tick();

    // No host page: full chunk waits; page arrives: request next cycle.
    add_data(16);
    early = 0;
    repeat (5) begin tick(); early |= int'(trigger_tlp); end
    chk("no_page_no_trigger", early, 0);
    huge_page_available = 1'b1;
    tick();
    chk("full_chunk_trigger", trigger_tlp, 1);
    chk("full_chunk_qw", qwords_to_send, 16);
    serve("full16");

    // Partial chunk is flushed only after the TLP timeout.
    add_data(5);
    early = 0;
    repeat (TTO) begin tick(); early |= int'(trigger_tlp); end
    chk("flush_not_early", early, 0);
    tick();
    chk("flush_trigger", trigger_tlp, 1);
    chk("flush_qw", qwords_to_send, 5);
    serve("flush5");

    // Reset while a request is pending drops it asynchronously.
    add_data(16);
    tick();
    chk("pre_reset_trigger", trigger_tlp, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_trigger", trigger_tlp, 0);
    chk("async_rst_last", send_last_tlp, 0);
    chk("async_rst_change", change_huge_page, 0);
    chk("async_rst_qw", qwords_to_send, 0);
    wr_i = 1020; cm_i = 1020; pu = 0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_reset_idle", trigger_tlp, 0);

    // Pointer wrap: 1020 -> 4 is 8 qwords, so it needs the timeout.
    wr_i = 4;
    early = 0;
    repeat (TTO) begin tick(); early |= int'(trigger_tlp); end
    chk("wrap_not_early", early, 0);
    tick();
    chk("wrap_trigger", trigger_tlp, 1);
    chk("wrap_qw", qwords_to_send, 8);
    serve("wrap");

    // Fill the page to HP-3, then a 10-qword burst yields a 3-qword last TLP.
    add_data(HP - 3 - pu);
    while (pu < HP - 3) serve("fill");
    add_data(10);
    tick();
    chk("last_req", send_last_tlp, 1);
    chk("last_qw", qwords_to_send, 3);
    commit(3);
    tick();
    chk("last_done_clr", send_last_tlp, 0);
    chk("last_close_req", change_huge_page, 1);
    pulse_change_ack();
    chk("last_close_clr", change_huge_page, 0);
    pu = 0;

    // Page at 100 qwords with an empty buffer closes after the page timeout.
    add_data(100 - avail_now());
    while (pu < 100) serve("fill100");
    early = 0;
    repeat (PTO) begin tick(); early |= cur_kind(); end
    chk("page_to_not_early", early, 0);
    tick();
    chk("page_to_close", change_huge_page, 1);
    pulse_change_ack();
    chk("page_to_clr", change_huge_page, 0);
    pu = 0;

    // Randomized fills; the model predicts request kind and size each time.
    for (int it = 0; it < 40; it++) begin
      if (avail_now() < 20) add_data(int'($urandom_range(1, 40)));
      serve("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
